// File: rtl/router_pkg.sv
// Shared definitions for the mesh_3x3 router: packet format, endpoint count
// and the default input-queue depth. The arbiter and the router top import
// this same package.
package router_pkg;

    localparam int PL        = 32;  // packet length including the valid bit
    localparam int REN       = 5;   // router endpoints per output arbiter
    localparam int REN_B     = 3;   // bits to encode an endpoint index
    localparam int DEPTH_DEF = 4;   // default input queue depth
    localparam int VALID_BIT = 0;   // bit the arbiter samples as "packet present"

    // Packets are indexed MSB-first so that bit 0 is the leftmost bit.
    typedef logic [0:PL-1] packet_t;

    // True when the packet carries a valid flag.
    function automatic logic pkt_valid(input packet_t p);
        return p[VALID_BIT];
    endfunction

endpackage

// File: rtl/router_input_queue_if.sv
// Handshake bundle between a packet source, the input queue and the
// arbiter slot. The queue takes the slave view, the traffic source and
// arbiter side take the master view.
interface router_input_queue_if
    import router_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CNT_B = $clog2(DEPTH + 1);

    packet_t            in_packet;
    logic               in_ready;
    packet_t            out_packet;
    logic               pop;
    logic [CNT_B-1:0]   count;
    logic               overflow;

    modport master (
        output in_packet,
        output pop,
        input  in_ready,
        input  out_packet,
        input  count,
        input  overflow
    );

    modport slave (
        input  in_packet,
        input  pop,
        output in_ready,
        output out_packet,
        output count,
        output overflow
    );

endinterface

// File: rtl/router_queue_ptr.sv
// Wrapping slot pointer for the input queue. Advances by one on adv_i and
// wraps from DEPTH-1 back to 0, so DEPTH need not be a power of two.
module router_queue_ptr #(
    parameter  int DEPTH = 4,
    localparam int PTR_B = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    output logic [PTR_B-1:0] ptr_o
);

    localparam logic [PTR_B-1:0] LAST_IDX = PTR_B'(DEPTH - 1);

    logic [PTR_B-1:0] ptr_q;
    logic [PTR_B-1:0] ptr_d;

    // Next pointer: hold, increment, or wrap at the last slot.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (ptr_q == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_B'(1);
            end
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/router_input_queue.sv
// Per-port packet FIFO feeding one round-robin arbiter input slot.
// First-word fall-through: the head slot is visible on out_packet whenever
// the queue holds anything, and reads as all zeros (valid bit low) when
// empty. in_ready and out_packet come only from registered state so the
// arbiter's grant never loops back combinationally into this port.
module router_input_queue
    import router_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int CNT_B = $clog2(DEPTH + 1),
    localparam int PTR_B = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    router_input_queue_if.slave  q
);

    localparam logic [CNT_B-1:0] FULL_CNT = CNT_B'(DEPTH);

    packet_t            slot_q [DEPTH];
    logic [CNT_B-1:0]   count_q;
    logic [CNT_B-1:0]   count_d;
    logic               overflow_q;
    logic               overflow_d;

    logic [PTR_B-1:0]   rd_ptr;
    logic [PTR_B-1:0]   wr_ptr;

    logic               full;
    logic               empty;
    logic               in_valid;
    logic               push;
    logic               do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_valid = pkt_valid(q.in_packet);

    // A valid packet arriving while full is dropped rather than stalled;
    // the link has no back-pressure beyond in_ready.
    assign push     = in_valid & ~full;
    assign do_pop   = q.pop & ~empty;

    router_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (push),
        .ptr_o (wr_ptr)
    );

    router_queue_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (do_pop),
        .ptr_o (rd_ptr)
    );

    // Occupancy and sticky drop flag next-state.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & full);
        case ({push, do_pop})
            2'b10:   count_d = count_q + CNT_B'(1);
            2'b01:   count_d = count_q - CNT_B'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset throws away the queue contents immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot storage carries no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr] <= q.in_packet;
        end
    end

    assign q.in_ready   = ~full;
    assign q.out_packet = empty ? '0 : slot_q[rd_ptr];
    assign q.count      = count_q;
    assign q.overflow   = overflow_q;

endmodule
